rtc_alarm_apb: RTL and testbench

RTC_ALARM_APB -- requirements
Module: rtc_alarm_apb

---
 rtl/rtc_alarm_apb.sv | 166 ++++++++++++++++
 tb/tb_rtc_alarm_apb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alarm_apb.sv
// Real-time counter with a programmable prescaler and ALARM_QTY compare
// channels. Each channel is one-shot or periodic. A zero-wait APB slave
// gives access to all registers.
module rtc_alarm_apb #(
  parameter int APB_AW    = 12,
  parameter int APB_DW    = 32,
  parameter int ALARM_QTY = 4,
  parameter int PRESC_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [APB_AW-1:0]    paddr_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [APB_DW-1:0]    pwdata_i,
  output logic [APB_DW-1:0]    prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic [ALARM_QTY-1:0] irq_o,
  output logic                 irq_any_o
);

  logic [1:0]                    rst_sync_q;
  logic                          rst_n_int;
  logic [31:0]                   addr;
  logic                          access, wr, mapped;
  logic                          ctrl_sel, presc_sel, count_sel, stat_sel, ien_sel;
  logic [ALARM_QTY-1:0]          cmp_sel, per_sel, cfg_sel;
  logic [31:0]                   rdata;

  logic                          en_q, en_d;
  logic [PRESC_W-1:0]            presc_q, presc_d, pcnt_q, pcnt_d;
  logic [31:0]                   count_q, count_d, count_inc;
  logic [ALARM_QTY-1:0]          status_q, status_d, ien_q, ien_d;
  logic [ALARM_QTY-1:0][31:0]    cmp_q, cmp_d, per_q, per_d;
  logic [ALARM_QTY-1:0]          aen_q, aen_d, periodic_q, periodic_d;
  logic                          clr_wr, count_wr, tick;
  logic [ALARM_QTY-1:0]          match;

  // Reset asserts asynchronously and releases two clocks later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  assign addr   = 32'(paddr_i);
  assign access = psel_i & penable_i & rst_n_int;
  assign wr     = access & pwrite_i;

  // Address decode and read-data mux; unmapped addresses read 0.
  always_comb begin
    ctrl_sel  = (addr == 32'h00);
    presc_sel = (addr == 32'h04);
    count_sel = (addr == 32'h08);
    stat_sel  = (addr == 32'h0C);
    ien_sel   = (addr == 32'h10);
    cmp_sel   = '0;
    per_sel   = '0;
    cfg_sel   = '0;
    for (int k = 0; k < ALARM_QTY; k++) begin
      cmp_sel[k] = (addr == 32'h20 + 32'(k) * 32'd16);
      per_sel[k] = (addr == 32'h24 + 32'(k) * 32'd16);
      cfg_sel[k] = (addr == 32'h28 + 32'(k) * 32'd16);
    end
    mapped = ctrl_sel | presc_sel | count_sel | stat_sel | ien_sel |
             (|cmp_sel) | (|per_sel) | (|cfg_sel);
    rdata = '0;
    if (ctrl_sel)  rdata = {31'd0, en_q};
    if (presc_sel) rdata = 32'(presc_q);
    if (count_sel) rdata = count_q;
    if (stat_sel)  rdata = 32'(status_q);
    if (ien_sel)   rdata = 32'(ien_q);
    for (int k = 0; k < ALARM_QTY; k++) begin
      if (cmp_sel[k]) rdata = cmp_q[k];
      if (per_sel[k]) rdata = per_q[k];
      if (cfg_sel[k]) rdata = {30'd0, periodic_q[k], aen_q[k]};
    end
  end

  assign pready_o  = 1'b1;
  assign pslverr_o = access & ~mapped;
  assign prdata_o  = access ? rdata : '0;
  assign irq_o     = status_q & ien_q;
  assign irq_any_o = |irq_o;

  // Next state: software writes, prescaler/counter advance and alarm matching.
  always_comb begin
    en_d       = en_q;
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
    count_d    = count_q;
    status_d   = status_q;
    ien_d      = ien_q;
    cmp_d      = cmp_q;
    per_d      = per_q;
    aen_d      = aen_q;
    periodic_d = periodic_q;
    match      = '0;

    // CLR and COUNT loads restart the timebase and cancel this cycle's tick.
    clr_wr    = wr & ctrl_sel & pwdata_i[1];
    count_wr  = wr & count_sel;
    tick      = en_q & (pcnt_q == presc_q) & ~clr_wr & ~count_wr;
    count_inc = count_q + 32'd1;

    if (clr_wr || count_wr) pcnt_d = '0;
    else if (en_q)          pcnt_d = (pcnt_q == presc_q) ? '0 : pcnt_q + PRESC_W'(1);

    if (clr_wr)        count_d = '0;
    else if (count_wr) count_d = pwdata_i;
    else if (tick)     count_d = count_inc;

    if (wr && ctrl_sel)  en_d    = pwdata_i[0];
    if (wr && presc_sel) presc_d = pwdata_i[PRESC_W-1:0];
    if (wr && ien_sel)   ien_d   = pwdata_i[ALARM_QTY-1:0];

    // Hardware update first, so a same-cycle software write overrides it.
    for (int k = 0; k < ALARM_QTY; k++) begin
      match[k] = tick & aen_q[k] & (count_inc == cmp_q[k]);
      if (match[k]) begin
        if (periodic_q[k] && (per_q[k] != 32'd0)) cmp_d[k] = cmp_q[k] + per_q[k];
        else                                      aen_d[k] = 1'b0;
      end
      if (wr && cmp_sel[k]) cmp_d[k] = pwdata_i;
      if (wr && per_sel[k]) per_d[k] = pwdata_i;
      if (wr && cfg_sel[k]) begin
        aen_d[k]      = pwdata_i[0];
        periodic_d[k] = pwdata_i[1];
      end
    end

    // W1C first, then hardware set, so a simultaneous set wins.
    if (wr && stat_sel) status_d = status_q & ~pwdata_i[ALARM_QTY-1:0];
    status_d = status_d | match;
  end

  // State registers, cleared asynchronously by the (synchronised) reset.
  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      en_q       <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      status_q   <= '0;
      ien_q      <= '0;
      cmp_q      <= '0;
      per_q      <= '0;
      aen_q      <= '0;
      periodic_q <= '0;
    end else begin
      en_q       <= en_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      status_q   <= status_d;
      ien_q      <= ien_d;
      cmp_q      <= cmp_d;
      per_q      <= per_d;
      aen_q      <= aen_d;
      periodic_q <= periodic_d;
    end
  end

endmodule

// File: tb/tb_rtc_alarm_apb.sv
// Directed bench for rtc_alarm_apb: timebase, alarms, W1C races, APB errors
// and asynchronous reset.
module tb_rtc_alarm_apb;

  localparam logic [11:0] A_CTRL = 12'h000, A_PRESC = 12'h004, A_COUNT = 12'h008;
  localparam logic [11:0] A_STAT = 12'h00C, A_IEN = 12'h010;
  localparam logic [11:0] A_CMP0 = 12'h020, A_CFG0 = 12'h028;
  localparam logic [11:0] A_CMP1 = 12'h030, A_PER1 = 12'h034, A_CFG1 = 12'h038;
  localparam logic [11:0] A_CMP2 = 12'h040, A_CFG2 = 12'h048, A_BAD = 12'h400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [3:0]  irq;
  logic        irq_any;

  int ntests = 0;
  int nfail  = 0;

  rtc_alarm_apb dut (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .psel_i(psel),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .irq_o(irq), .irq_any_o(irq_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write commits on the second rising edge after the call.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check(tag, d, exp);
  endtask

  // Called just after an enabling write committed at edge Ec: stops at Ec+n.
  task automatic stop_after(input int n);
    repeat (n - 2) @(posedge clk);
    #1 apb_write(A_CTRL, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    rst_n = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("pready", 32'(pready), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd_chk(A_CTRL, 32'h0, "rst_ctrl");
    rd_chk(A_COUNT, 32'h0, "rst_count");
    rd_chk(A_STAT, 32'h0, "rst_status");
    apb_read(A_PRESC, d, e);
    check("mapped_pslverr", 32'(e), 32'h0);
    check("rst_presc", d, 32'h0);

    // PRESC=3 for 20 cycles: ticks at 4,8,12,16,20
    apb_write(A_PRESC, 32'd3);
    apb_write(A_CTRL, 32'h1);
    stop_after(20);
    rd_chk(A_COUNT, 32'd5, "presc3_20cyc");
    rd_chk(A_CTRL, 32'h0, "ctrl_en_off");
    apb_write(A_CTRL, 32'h3);
    stop_after(3);
    rd_chk(A_COUNT, 32'd0, "presc3_3cyc");
    apb_write(A_CTRL, 32'h3);
    stop_after(4);
    rd_chk(A_COUNT, 32'd1, "presc3_4cyc");

    // Wrap to 0 with one-shot alarm 0
    apb_write(A_PRESC, 32'd0);
    apb_write(A_COUNT, 32'hFFFF_FFFE);
    rd_chk(A_COUNT, 32'hFFFF_FFFE, "count_load");
    apb_write(A_CMP0, 32'h0);
    apb_write(A_CFG0, 32'h1);
    apb_write(A_IEN, 32'h1);
    apb_write(A_CTRL, 32'h1);
    check("wrap_irq_e0", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("wrap_irq_e1", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("wrap_irq_e2", 32'(irq), 32'h1);
    check("wrap_irq_any", 32'(irq_any), 32'h1);
    apb_write(A_CTRL, 32'h0);
    rd_chk(A_COUNT, 32'd2, "wrap_count");
    rd_chk(A_CFG0, 32'h0, "oneshot_aen_clr");
    rd_chk(A_STAT, 32'h1, "wrap_status");
    apb_write(A_STAT, 32'h1);
    apb_write(A_IEN, 32'h0);
    rd_chk(A_STAT, 32'h0, "w1c_status0");

    // Periodic alarm 1: CMP=10, PER=5
    apb_write(A_CTRL, 32'h2);
    apb_write(A_CMP1, 32'd10);
    apb_write(A_PER1, 32'd5);
    apb_write(A_CFG1, 32'h3);
    apb_write(A_CTRL, 32'h1);
    stop_after(10);
    rd_chk(A_COUNT, 32'd10, "per_count10");
    rd_chk(A_STAT, 32'h2, "per_status_10");
    rd_chk(A_CMP1, 32'd15, "per_cmp15");
    apb_write(A_STAT, 32'h2);
    rd_chk(A_STAT, 32'h0, "per_w1c");
    apb_write(A_CTRL, 32'h1);
    stop_after(4);
    rd_chk(A_COUNT, 32'd14, "per_count14");
    rd_chk(A_STAT, 32'h0, "per_status_14");
    apb_write(A_CTRL, 32'h1);
    stop_after(2);
    rd_chk(A_COUNT, 32'd16, "per_count16");
    rd_chk(A_STAT, 32'h2, "per_status_15");
    rd_chk(A_CMP1, 32'd20, "per_cmp20");
    rd_chk(A_CFG1, 32'h3, "per_aen_kept");
    apb_write(A_STAT, 32'h2);

    // W1C of STATUS2 in the same cycle as the alarm-2 match
    apb_write(A_CTRL, 32'h2);
    apb_write(A_CMP2, 32'd3);
    apb_write(A_CFG2, 32'h1);
    apb_write(A_CTRL, 32'h1);
    repeat (1) @(posedge clk);
    #1 apb_write(A_STAT, 32'h4);
    apb_write(A_CTRL, 32'h0);
    rd_chk(A_STAT, 32'h4, "race_status2");
    rd_chk(A_CFG2, 32'h0, "race_aen2_clr");

    // Unmapped address
    apb_read(A_BAD, d, e);
    check("bad_rd_pslverr", 32'(e), 32'h1);
    check("bad_rd_data", d, 32'h0);
    apb_write(A_BAD, 32'hFFFF_FFFF);
    rd_chk(A_CTRL, 32'h0, "bad_wr_ctrl");
    rd_chk(A_PRESC, 32'h0, "bad_wr_presc");
    rd_chk(A_IEN, 32'h0, "bad_wr_ien");
    rd_chk(A_COUNT, 32'd5, "bad_wr_count");

    // Reset mid-count with irq=0101
    apb_write(A_CTRL, 32'h2);
    apb_write(A_CMP0, 32'd2);
    apb_write(A_CFG0, 32'h1);
    apb_write(A_IEN, 32'h5);
    apb_write(A_CTRL, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_irq", 32'(irq), 32'h5);
    paddr = A_BAD; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
    #1;
    check("pre_rst_pslverr", 32'(pslverr), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_irq_any", 32'(irq_any), 32'h0);
    check("arst_pslverr", 32'(pslverr), 32'h0);
    check("arst_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd_chk(A_CTRL, 32'h0, "post_ctrl");
    rd_chk(A_COUNT, 32'h0, "post_count");
    rd_chk(A_STAT, 32'h0, "post_status");
    rd_chk(A_IEN, 32'h0, "post_ien");
    rd_chk(A_CMP0, 32'h0, "post_cmp0");
    rd_chk(A_CFG0, 32'h0, "post_cfg0");
    rd_chk(A_CMP1, 32'h0, "post_cmp1");
    rd_chk(A_PER1, 32'h0, "post_per1");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
